// File: rtl/io_bus_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the shared IO device bus.
// One transaction in flight; loads return data to the owner with a one-cycle rvalid pulse.
module io_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [2:0]        req0_funct3,
  input  logic              req0_we,
  input  logic [3:0]        req0_cs,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [2:0]        req1_funct3,
  input  logic              req1_we,
  input  logic [3:0]        req1_cs,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [3:0]        bus_cs,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [2:0]        bus_funct3,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // RD_LAT is limited to 0..3, so a 2-bit cycle counter suffices.
  localparam logic [1:0] LAST_CNT = 2'(RD_LAT);

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic              owner;
  logic              sel;
  logic              handshake;
  logic              capture;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        lat_funct3;
  logic              lat_we;
  logic [3:0]        lat_cs;

  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_grant;
    else if (req1_valid)          sel = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !sel;
  assign req1_ready = (state == IDLE) && req1_valid && sel;
  assign handshake  = req0_ready || req1_ready;
  assign capture    = (state == ISSUE) && !lat_we && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = ISSUE;
      ISSUE: begin
        if (lat_we)                 state_nxt = IDLE;
        else if (cnt == LAST_CNT)   state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      lat_we     <= 1'b0;
      lat_cs     <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      if (handshake) begin
        lat_addr   <= sel ? req1_addr   : req0_addr;
        lat_wdata  <= sel ? req1_wdata  : req0_wdata;
        lat_funct3 <= sel ? req1_funct3 : req0_funct3;
        lat_we     <= sel ? req1_we     : req0_we;
        lat_cs     <= sel ? req1_cs     : req0_cs;
        owner      <= sel;
        last_grant <= sel;
        cnt        <= '0;
      end else if (state == ISSUE) begin
        cnt <= cnt + 2'd1;
      end
      if (capture && !owner) req0_rdata <= bus_rdata;
      if (capture && owner)  req1_rdata <= bus_rdata;
    end
  end

  assign busy        = (state != IDLE);
  assign bus_cs      = (state == ISSUE) ? lat_cs : '0;
  assign bus_we      = (state == ISSUE) && lat_we;
  assign bus_addr    = lat_addr;
  assign bus_wdata   = lat_wdata;
  assign bus_funct3  = lat_funct3;
  assign req0_rvalid = (state == RESP) && !owner;
  assign req1_rvalid = (state == RESP) && owner;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench: three arbiters (RD_LAT 0, 1, 3) share one requester stimulus;
// each sees an IO model returning {addr[15:0], cycle[15:0]} so capture timing is visible.
module tb_io_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v0, v1, we0, we1;
  logic [31:0] a0, a1, w0, w1;
  logic [2:0]  f0, f1;
  logic [3:0]  cs0, cs1;

  logic        r0_ready[3], r1_ready[3], r0_rvalid[3], r1_rvalid[3];
  logic        busy[3], lg[3], b_we[3];
  logic [31:0] r0_rdata[3], r1_rdata[3], b_addr[3], b_wdata[3], b_rdata[3];
  logic [3:0]  b_cs[3];
  logic [2:0]  b_f3[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign b_rdata[g] = {b_addr[g][15:0], cyc[15:0]};
    io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT((g == 2) ? 3 : g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(r0_ready[g]), .req0_addr(a0), .req0_wdata(w0),
      .req0_funct3(f0), .req0_we(we0), .req0_cs(cs0),
      .req0_rvalid(r0_rvalid[g]), .req0_rdata(r0_rdata[g]),
      .req1_valid(v1), .req1_ready(r1_ready[g]), .req1_addr(a1), .req1_wdata(w1),
      .req1_funct3(f1), .req1_we(we1), .req1_cs(cs1),
      .req1_rvalid(r1_rvalid[g]), .req1_rdata(r1_rdata[g]),
      .bus_cs(b_cs[g]), .bus_addr(b_addr[g]), .bus_wdata(b_wdata[g]),
      .bus_funct3(b_f3[g]), .bus_we(b_we[g]), .bus_rdata(b_rdata[g]),
      .busy(busy[g]), .last_grant(lg[g])
    );
  end

  typedef struct {
    int          k;
    int          due;
    bit          who;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 2) ? 3 : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit who, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] cs);
    if (who) begin v1 = 1'b1; we1 = we; a1 = addr; w1 = wdata; cs1 = cs; f1 = 3'd2; end
    else     begin v0 = 1'b1; we0 = we; a0 = addr; w0 = wdata; cs0 = cs; f0 = 3'd5; end
  endtask

  // Called in the handshake cycle; data is what the IO model shows on the last ISSUE cycle.
  task automatic push_load(input bit who, input logic [31:0] addr);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.k    = k;
      e.who  = who;
      e.due  = cyc + lat(k) + 2;
      e.data = {addr[15:0], 16'(cyc + lat(k) + 1)};
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk($sformatf("rvalid_missing_dut%0d", sb[0].k), 0, 1);
      void'(sb.pop_front());
    end
    for (int k = 0; k < 3; k++) begin
      if (r0_rvalid[k] || r1_rvalid[k]) begin
        if (sb.size() == 0) begin
          chk($sformatf("rvalid_unexpected_dut%0d", k), 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rv_dut", k, e.k);
          chk($sformatf("rv_cycle_dut%0d", k), cyc, e.due);
          chk($sformatf("rv_owner_dut%0d", k), r1_rvalid[k], e.who);
          chk($sformatf("rv_both_dut%0d", k), r0_rvalid[k] & r1_rvalid[k], 0);
          chk($sformatf("rv_data_dut%0d", k), e.who ? r1_rdata[k] : r0_rdata[k], e.data);
        end
      end
    end
  end

  int          c;
  logic [31:0] aa[2];

  initial begin
    rst_n = 1'b0;
    v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; w0 = '0; w1 = '0;
    f0 = '0; f1 = '0; cs0 = '0; cs1 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", busy[k], 0);
      chk("rst_last_grant", lg[k], 1);
      chk("rst_bus_cs", b_cs[k], 0);
      chk("rst_bus_addr", b_addr[k], 0);
      chk("rst_rdata0", r0_rdata[k], 0);
    end
    rst_n = 1'b1;
    tick();

    // req0 store
    drive(0, 1, 32'h4, 32'hDEADBEEF, 4'hF);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("st_ready0", r0_ready[k], 1);
      chk("st_ready1", r1_ready[k], 0);
    end
    tick(); v0 = 0; #1;
    for (int k = 0; k < 3; k++) begin
      chk("st_we", b_we[k], 1);
      chk("st_addr", b_addr[k], 32'h4);
      chk("st_wdata", b_wdata[k], 32'hDEADBEEF);
      chk("st_cs", b_cs[k], 4'hF);
      chk("st_f3", b_f3[k], 3'd5);
      chk("st_busy", busy[k], 1);
      chk("st_ready0_issue", r0_ready[k], 0);
      chk("st_last_grant", lg[k], 0);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("st_we_after", b_we[k], 0);
      chk("st_cs_after", b_cs[k], 0);
      chk("st_busy_after", busy[k], 0);
      chk("st_addr_hold", b_addr[k], 32'h4);
    end

    // req1 load, then req0 load
    for (int r = 1; r >= 0; r--) begin
      c = cyc;
      drive(r[0], 0, (r == 1) ? 32'h10 : 32'h20, 32'h0, 4'h3);
      push_load(r[0], (r == 1) ? 32'h10 : 32'h20);
      #1;
      for (int k = 0; k < 3; k++) chk("ld_ready", r[0] ? r1_ready[k] : r0_ready[k], 1);
      tick(); v0 = 0; v1 = 0; #1;
      for (int k = 0; k < 3; k++) begin
        chk("ld_we", b_we[k], 0);
        chk("ld_cs", b_cs[k], 4'h3);
        chk("ld_f3", b_f3[k], r[0] ? 3'd2 : 3'd5);
      end
      repeat (6) tick();
      for (int k = 0; k < 3; k++)
        chk("ld_rdata_hold", r[0] ? r1_rdata[k] : r0_rdata[k],
            {(r == 1) ? 16'h0010 : 16'h0020, 16'(c + lat(k) + 1)});
    end

    // req1 load with req0 arriving during ISSUE and dropping before IDLE
    drive(1, 0, 32'h30, 32'h0, 4'h1);
    push_load(1, 32'h30);
    tick(); v1 = 0;
    drive(0, 1, 32'h40, 32'h55, 4'hF);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("drop_ready0_a", r0_ready[k], 0);
      chk("drop_addr_a", b_addr[k], 32'h30);
      chk("drop_we_a", b_we[k], 0);
    end
    tick();
    for (int k = 0; k < 3; k++) chk("drop_ready0_b", r0_ready[k], 0);
    v0 = 0;
    repeat (6) tick();
    for (int k = 0; k < 3; k++) begin
      chk("drop_addr_idle", b_addr[k], 32'h30);
      chk("drop_last_grant", lg[k], 1);
      chk("drop_busy", busy[k], 0);
    end

    // Reset in the middle of a req0 load
    drive(0, 0, 32'h50, 32'h0, 4'hF);
    push_load(0, 32'h50);
    tick(); v0 = 0; #1;
    for (int k = 0; k < 3; k++) chk("mid_cs_before", b_cs[k], 4'hF);
    rst_n = 1'b0;
    sb.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_cs", b_cs[k], 0);
      chk("mid_rst_we", b_we[k], 0);
      chk("mid_rst_busy", busy[k], 0);
      chk("mid_rst_last_grant", lg[k], 1);
      chk("mid_rst_rdata0", r0_rdata[k], 0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Both requesters continuously valid: grants must alternate 0,1,0,1
    aa[0] = 32'h100;
    aa[1] = 32'h200;
    drive(0, 1, aa[0], 32'hA0, 4'h1);
    drive(1, 1, aa[1], 32'hB1, 4'h2);
    #1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("alt%0d_ready0", i), r0_ready[k], (i % 2) == 0);
        chk($sformatf("alt%0d_ready1", i), r1_ready[k], (i % 2) == 1);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("alt%0d_addr", i), b_addr[k], aa[i % 2]);
        chk($sformatf("alt%0d_we", i), b_we[k], 1);
        chk($sformatf("alt%0d_last_grant", i), lg[k], (i % 2) == 1);
      end
      tick();
    end
    v0 = 0; v1 = 0;
    repeat (4) tick();

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
